// File: rtl/gshare_pkg.sv
// rtl/gshare_pkg.sv - shared types, defaults and counter helper for the gshare branch controller
package gshare_pkg;

  localparam int PC_W_DEF  = 8;
  localparam int GHR_W_DEF = 8;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_UPDATE = 1'b1
  } state_e;

  // Checkpoint layout at the default history width; the controller builds a
  // width-matched copy of this layout from its own GHR_W parameter.
  typedef struct packed {
    logic [GHR_W_DEF-1:0] idx;
    logic                 pred;
    logic [GHR_W_DEF-1:0] ghr;
  } ckpt_t;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/gshare_ckpt_fifo.sv
// rtl/gshare_ckpt_fifo.sv - in-order checkpoint queue for in-flight branches
module gshare_ckpt_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally at DEPTH; clear drops every entry at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; only slots below count are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/gshare_branch_ctrl.sv
// rtl/gshare_branch_ctrl.sv - gshare PHT sequencer with speculative GHR and checkpoint queue (optional GSHARE_CTRL_STATS_EN)
module gshare_branch_ctrl
  import gshare_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int GHR_W = GHR_W_DEF,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_valid,
  output logic             pred_ready,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic             res_taken,
  output logic [GHR_W-1:0] pht_idx,
  output logic             pht_we,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata,
  output logic             flush,
  output logic [GHR_W-1:0] ghr,
  output logic [CW-1:0]    inflight
`ifdef GSHARE_CTRL_STATS_EN
  ,
  output logic [15:0]      stat_total,
  output logic [15:0]      stat_correct
`endif
);

  typedef struct packed {
    logic [GHR_W-1:0] idx;
    logic             pred;
    logic [GHR_W-1:0] ghr;
  } entry_t;

  localparam int EW = $bits(entry_t);

  state_e           state_q, state_d;
  logic [GHR_W-1:0] ghr_q;
  entry_t           held;
  logic             held_taken;
  entry_t           head;
  entry_t           new_entry;
  logic [EW-1:0]    fifo_rdata;
  logic             push, pop, clear, mispredict;
  logic             full, empty;

  assign ghr       = ghr_q;
  assign head      = entry_t'(fifo_rdata);
  assign new_entry = '{idx: pht_idx, pred: pred_taken, ghr: ghr_q};

  gshare_ckpt_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .wdata (new_entry),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty),
    .count (inflight)
  );

  // Handshakes, PHT port steering and next state; everything quiet while in reset.
  always_comb begin
    state_d    = state_q;
    pred_ready = 1'b0;
    res_ready  = 1'b0;
    pred_taken = 1'b0;
    pht_idx    = '0;
    pht_we     = 1'b0;
    pht_wdata  = 2'b00;
    flush      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    mispredict = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          res_ready  = !empty;
          pred_ready = !full && !(res_valid && res_ready);
          pht_idx    = pred_pc[GHR_W-1:0] ^ ghr_q;
          pred_taken = pht_rdata[1];
          push       = pred_valid && pred_ready;
          pop        = res_valid && res_ready;
          if (pop) state_d = S_UPDATE;
        end
        S_UPDATE: begin
          pht_idx    = held.idx;
          pht_we     = 1'b1;
          pht_wdata  = sat_update(pht_rdata, held_taken);
          mispredict = (held_taken != held.pred);
          flush      = mispredict;
          clear      = mispredict;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, speculative history and the resolving branch's checkpoint.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ghr_q      <= '0;
      held       <= '0;
      held_taken <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        held       <= head;
        held_taken <= res_taken;
      end
      if (push)            ghr_q <= {ghr_q[GHR_W-2:0], pred_taken};
      else if (mispredict) ghr_q <= {held.ghr[GHR_W-2:0], held_taken};
    end
  end

`ifdef GSHARE_CTRL_STATS_EN
  // Resolution and correct-prediction counters, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_total   <= '0;
      stat_correct <= '0;
    end else if (state_q == S_UPDATE) begin
      if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
      if (!mispredict && stat_correct != 16'hFFFF) stat_correct <= stat_correct + 16'd1;
    end
  end
`endif

endmodule
